// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
// Bridges user_io (PS/2 scancodes, two joysticks, OSD coin button) to the
// berzerk core. Key make/break events are latched per function, merged with
// both joysticks and presented as registered levels. Coin requests are turned
// into fixed-width pulses separated by a mandatory low gap, and a small
// saturating queue holds credits that arrive while a pulse is in progress.
module arcade_input_ctrl #(
    parameter int COIN_PULSE = 500000,   // coin1 high time, clock_10 cycles
    parameter int COIN_GAP   = 1000000,  // enforced low time after each pulse
    parameter int COIN_QMAX  = 3         // pending credit ceiling (fits in 2 bits)
) (
    input  logic       clock_10,
    input  logic       reset,
    input  logic       key_strobe,
    input  logic       key_pressed,
    input  logic [7:0] key_code,
    input  logic [7:0] joystick_0,
    input  logic [7:0] joystick_1,
    input  logic       coin_ext,
    output logic       m_up,
    output logic       m_down,
    output logic       m_left,
    output logic       m_right,
    output logic       m_fire1,
    output logic       m_fire2,
    output logic       m_fire3,
    output logic       m_hyperflip,
    output logic       start1,
    output logic       start2,
    output logic       coin1,
    output logic [1:0] coin_pending
);

    // Key latch indices. Bits 0..7 deliberately follow the joystick bit
    // layout so the merge is a plain bitwise OR.
    localparam int K_RIGHT  = 0;
    localparam int K_LEFT   = 1;
    localparam int K_DOWN   = 2;
    localparam int K_UP     = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_FIRE2  = 5;
    localparam int K_FIRE3  = 6;
    localparam int K_HYPER  = 7;
    localparam int K_START1 = 8;
    localparam int K_START2 = 9;
    localparam int K_COIN   = 10;
    localparam int NKEYS    = 11;
    localparam int NMERGE   = 10;

    // Coin timer is sized for the longer of the two phases; loads are N-1
    // and the count stops at zero, so it never wraps.
    localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP - 1);
    localparam logic [1:0]       QMAX_L     = 2'(COIN_QMAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } coin_state_t;

    logic [NKEYS-1:0]  key_sel;
    logic [NKEYS-1:0]  key_reg;
    logic [NKEYS-1:0]  key_next;
    logic [NMERGE-1:0] merged_reg;
    logic [NMERGE-1:0] merged_next;

    logic              creq_reg;
    logic              creq_prev_reg;
    logic              coin_req;
    logic              take_credit;
    logic [1:0]        pending_reg;
    logic [1:0]        pending_next;
    coin_state_t       state_reg;
    coin_state_t       state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              coin1_reg;

    // Scancode decoder: each mapped code selects exactly one latch.
    always_comb begin
        key_sel = '0;
        case (key_code)
            8'h75:   key_sel[K_UP]     = 1'b1;
            8'h72:   key_sel[K_DOWN]   = 1'b1;
            8'h6B:   key_sel[K_LEFT]   = 1'b1;
            8'h74:   key_sel[K_RIGHT]  = 1'b1;
            8'h29:   key_sel[K_FIRE1]  = 1'b1;
            8'h11:   key_sel[K_FIRE2]  = 1'b1;
            8'h14:   key_sel[K_FIRE3]  = 1'b1;
            8'h76:   key_sel[K_COIN]   = 1'b1;
            8'h05:   key_sel[K_START1] = 1'b1;
            8'h06:   key_sel[K_START2] = 1'b1;
            8'h04:   key_sel[K_HYPER]  = 1'b1;
            default: key_sel = '0;
        endcase
    end

    // Per-key latch update and joystick merge, one slice per bit.
    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            assign key_next[gi] = (key_strobe && key_sel[gi]) ? key_pressed : key_reg[gi];
        end
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_next[gi] = key_reg[gi] | joystick_0[gi] | joystick_1[gi];
        end
    endgenerate

    assign merged_next[8] = key_reg[K_START1];
    assign merged_next[9] = key_reg[K_START2];

    // Key latches and merged output register.
    always_ff @(posedge clock_10) begin
        if (reset) begin
            key_reg    <= '0;
            merged_reg <= '0;
        end else begin
            key_reg    <= key_next;
            merged_reg <= merged_next;
        end
    end

    // A coin request is a rising edge of the registered key/OSD coin level.
    assign coin_req = creq_reg & ~creq_prev_reg;

    // Coin FSM next state, timer and credit consumption.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        take_credit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg != 2'd0) begin
                    state_next  = ST_PULSE;
                    cnt_next    = PULSE_LOAD;
                    take_credit = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pending credits: a request and a take in the same cycle cancel out.
    always_comb begin
        pending_next = pending_reg;
        case ({coin_req, take_credit})
            2'b10: begin
                if (pending_reg != QMAX_L) begin
                    pending_next = pending_reg + 2'd1;
                end
            end
            2'b01:   pending_next = pending_reg - 2'd1;
            default: pending_next = pending_reg;
        endcase
    end

    // Coin request edge detector, queue, FSM and registered coin1.
    // coin1 is registered from state_next so it is high exactly while in PULSE.
    always_ff @(posedge clock_10) begin
        if (reset) begin
            creq_reg      <= 1'b0;
            creq_prev_reg <= 1'b0;
            pending_reg   <= 2'd0;
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            coin1_reg     <= 1'b0;
        end else begin
            creq_reg      <= key_reg[K_COIN] | coin_ext;
            creq_prev_reg <= creq_reg;
            pending_reg   <= pending_next;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            coin1_reg     <= (state_next == ST_PULSE);
        end
    end

    assign m_right      = merged_reg[K_RIGHT];
    assign m_left       = merged_reg[K_LEFT];
    assign m_down       = merged_reg[K_DOWN];
    assign m_up         = merged_reg[K_UP];
    assign m_fire1      = merged_reg[K_FIRE1];
    assign m_fire2      = merged_reg[K_FIRE2];
    assign m_fire3      = merged_reg[K_FIRE3];
    assign m_hyperflip  = merged_reg[K_HYPER];
    assign start1       = merged_reg[8];
    assign start2       = merged_reg[9];
    assign coin1        = coin1_reg;
    assign coin_pending = pending_reg;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl with short coin timing (PULSE=4,
// GAP=6). Stimulus pushes hand-computed expectations (value + cycle) into
// queues; the monitor pops an entry whenever the matching DUT output changes.
module tb_arcade_input_ctrl;

    localparam int TB_PULSE = 4;
    localparam int TB_GAP   = 6;
    localparam int TB_QMAX  = 3;

    typedef struct {
        string       name;
        logic [12:0] val;
        int          cyc;
    } exp_t;

    logic       clock_10 = 1'b0;
    logic       reset;
    logic       key_strobe;
    logic       key_pressed;
    logic [7:0] key_code;
    logic [7:0] joystick_0;
    logic [7:0] joystick_1;
    logic       coin_ext;
    logic       m_up, m_down, m_left, m_right;
    logic       m_fire1, m_fire2, m_fire3, m_hyperflip;
    logic       start1, start2, coin1;
    logic [1:0] coin_pending;

    int   cyc     = 0;
    logic mon_en  = 1'b0;
    logic done    = 1'b0;

    exp_t ctrl_q[$];
    exp_t pend_q[$];
    exp_t rise_q[$];
    exp_t snap_q[$];

    logic [9:0]  ctrl_v;
    logic [12:0] snap_v;

    assign ctrl_v = {m_up, m_down, m_left, m_right, m_fire1, m_fire2, m_fire3,
                     m_hyperflip, start1, start2};
    assign snap_v = {ctrl_v, coin1, coin_pending};

    arcade_input_ctrl #(
        .COIN_PULSE(TB_PULSE),
        .COIN_GAP  (TB_GAP),
        .COIN_QMAX (TB_QMAX)
    ) dut (
        .clock_10    (clock_10),
        .reset       (reset),
        .key_strobe  (key_strobe),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .coin_ext    (coin_ext),
        .m_up        (m_up),
        .m_down      (m_down),
        .m_left      (m_left),
        .m_right     (m_right),
        .m_fire1     (m_fire1),
        .m_fire2     (m_fire2),
        .m_fire3     (m_fire3),
        .m_hyperflip (m_hyperflip),
        .start1      (start1),
        .start2      (start2),
        .coin1       (coin1),
        .coin_pending(coin_pending)
    );

    always #5 clock_10 = ~clock_10;

    initial begin
        forever begin
            @(posedge clock_10);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, cycle %0d, required finish before 20000", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_10);
            #1;
        end
    endtask

    task automatic push(input int which, input string nm, input logic [12:0] v, input int c);
        exp_t e;
        e.name = nm;
        e.val  = v;
        e.cyc  = c;
        case (which)
            0:       ctrl_q.push_back(e);
            1:       pend_q.push_back(e);
            2:       rise_q.push_back(e);
            default: snap_q.push_back(e);
        endcase
    endtask

    // Key strobe: merged output expected two edges later when chg is set.
    task automatic do_key(input logic [7:0] code, input logic pr, input logic chg,
                          input logic [9:0] ev, input string nm);
        key_code    = code;
        key_pressed = pr;
        key_strobe  = 1'b1;
        if (chg) push(0, nm, {3'b000, ev}, cyc + 2);
        tick(1);
        key_strobe = 1'b0;
        tick(3);
    endtask

    // Joystick change: merged output expected one edge later.
    task automatic do_joy(input int port, input logic [7:0] v, input logic [9:0] ev,
                          input string nm);
        if (port == 0) joystick_0 = v;
        else           joystick_1 = v;
        push(0, nm, {3'b000, ev}, cyc + 1);
        tick(3);
    endtask

    task automatic coin_burst5();
        for (int k = 0; k < 5; k++) begin
            coin_ext = 1'b1;
            tick(1);
            coin_ext = 1'b0;
            tick(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        reset       = 1'b1;
        key_strobe  = 1'b0;
        key_pressed = 1'b0;
        key_code    = 8'h00;
        joystick_0  = 8'h00;
        joystick_1  = 8'h00;
        coin_ext    = 1'b0;
        repeat (3) begin
            @(posedge clock_10);
            #1;
        end
        reset = 1'b0;
        push(3, "reset_state", 13'h0000, cyc);
        mon_en = 1'b1;
        tick(2);

        // Keymap / merge vectors (expected vector order: up,down,left,right,
        // fire1,fire2,fire3,hyperflip,start1,start2).
        do_key(8'h75, 1'b1, 1'b1, 10'h200, "up_make");
        do_key(8'h75, 1'b0, 1'b1, 10'h000, "up_break");
        do_joy(1, 8'h10, 10'h020, "joy1_fire1");
        do_joy(1, 8'h00, 10'h000, "joy1_release");
        do_key(8'h05, 1'b1, 1'b1, 10'h002, "start1_make");
        do_key(8'h04, 1'b1, 1'b1, 10'h006, "hyper_make");
        do_key(8'h6B, 1'b1, 1'b1, 10'h086, "left_make");
        do_joy(0, 8'h01, 10'h0C6, "joy0_right");
        do_joy(0, 8'h00, 10'h086, "joy0_release");
        do_key(8'h74, 1'b1, 1'b1, 10'h0C6, "right_make");
        do_key(8'h29, 1'b1, 1'b1, 10'h0E6, "fire1_make");
        do_key(8'h11, 1'b1, 1'b1, 10'h0F6, "fire2_make");
        do_key(8'h14, 1'b1, 1'b1, 10'h0FE, "fire3_make");
        do_key(8'h72, 1'b1, 1'b1, 10'h1FE, "down_make");
        do_key(8'h06, 1'b1, 1'b1, 10'h1FF, "start2_make");
        do_key(8'h12, 1'b1, 1'b0, 10'h1FF, "unmapped_make");
        do_key(8'h04, 1'b0, 1'b1, 10'h1FB, "hyper_break");
        do_joy(1, 8'h80, 10'h1FF, "joy1_hyper");
        do_joy(1, 8'h00, 10'h1FB, "joy1_hyper_release");
        do_key(8'h75, 1'b1, 1'b1, 10'h3FB, "up_make2");

        // Single coin_ext pulse: request edge, credit, pulse of TB_PULSE cycles.
        b = cyc;
        push(1, "pend_single_up", 13'd1, b + 2);
        push(1, "pend_single_dn", 13'd0, b + 3);
        push(2, "rise_single", 13'd1, b + 3);
        coin_ext = 1'b1;
        tick(1);
        coin_ext = 1'b0;
        tick(20);

        // Coin key held: one pulse only; coin_ext while held adds nothing.
        b = cyc;
        push(1, "pend_key_up", 13'd1, b + 3);
        push(1, "pend_key_dn", 13'd0, b + 4);
        push(2, "rise_key", 13'd1, b + 4);
        do_key(8'h76, 1'b1, 1'b0, 10'h000, "coin_make");
        tick(17);
        coin_ext = 1'b1;
        tick(1);
        coin_ext = 1'b0;
        tick(5);
        do_key(8'h76, 1'b0, 1'b0, 10'h000, "coin_break");
        tick(20);

        // Five request edges: queue saturates at 3, fifth dropped, 4 pulses.
        b = cyc;
        push(1, "pend_sat_a", 13'd1, b + 2);
        push(1, "pend_sat_b", 13'd0, b + 3);
        push(1, "pend_sat_c", 13'd1, b + 4);
        push(1, "pend_sat_d", 13'd2, b + 6);
        push(1, "pend_sat_e", 13'd3, b + 8);
        push(1, "pend_sat_f", 13'd2, b + 14);
        push(1, "pend_sat_g", 13'd1, b + 25);
        push(1, "pend_sat_h", 13'd0, b + 36);
        push(2, "rise_sat_1", 13'd1, b + 3);
        push(2, "rise_sat_2", 13'd1, b + 14);
        push(2, "rise_sat_3", 13'd1, b + 25);
        push(2, "rise_sat_4", 13'd1, b + 36);
        coin_burst5();
        tick(45);

        // Reset during the second pulse while two credits are queued.
        b = cyc;
        push(1, "pend_rst_a", 13'd1, b + 2);
        push(1, "pend_rst_b", 13'd0, b + 3);
        push(1, "pend_rst_c", 13'd1, b + 4);
        push(1, "pend_rst_d", 13'd2, b + 6);
        push(1, "pend_rst_e", 13'd3, b + 8);
        push(1, "pend_rst_f", 13'd2, b + 14);
        push(2, "rise_rst_1", 13'd1, b + 3);
        push(2, "rise_rst_2", 13'd1, b + 14);
        coin_burst5();
        tick(5);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick(1);
        push(3, "reset_mid_pulse", 13'h0000, cyc);
        tick(2);
        reset = 1'b0;
        tick(1);
        push(3, "key_cleared_by_reset", 13'h0000, cyc);
        mon_en = 1'b1;
        tick(40);
        do_key(8'h75, 1'b1, 1'b1, 10'h200, "up_after_reset");
        tick(2);
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t       e;
        int         n_vec;
        int         n_err;
        int         rise_cyc;
        logic [9:0] prev_ctrl;
        logic       prev_coin;
        logic [1:0] prev_pend;
        logic       en_d;
        n_vec     = 0;
        n_err     = 0;
        rise_cyc  = 0;
        prev_ctrl = '0;
        prev_coin = 1'b0;
        prev_pend = '0;
        en_d      = 1'b0;
        forever begin
            @(negedge clock_10);
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                e = snap_q.pop_front();
                n_vec++;
                if (snap_v !== e.val || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             e.name, snap_v, cyc, e.val, e.cyc);
                end
            end
            if (en_d && !mon_en) begin
                n_vec++;
                if (ctrl_q.size() + pend_q.size() + rise_q.size() != 0) begin
                    n_err++;
                    $display("FAIL pre_reset_drain: %0d expected events still queued, required 0",
                             ctrl_q.size() + pend_q.size() + rise_q.size());
                end
                ctrl_q.delete();
                pend_q.delete();
                rise_q.delete();
            end
            en_d = mon_en;
            if (!mon_en) begin
                prev_ctrl = '0;
                prev_coin = 1'b0;
                prev_pend = '0;
            end else begin
                if (ctrl_v !== prev_ctrl) begin
                    n_vec++;
                    if (ctrl_q.size() == 0) begin
                        n_err++;
                        $display("FAIL ctrl_unexpected: got %h at cycle %0d, required no change from %h",
                                 ctrl_v, cyc, prev_ctrl);
                    end else begin
                        e = ctrl_q.pop_front();
                        if (ctrl_v !== e.val[9:0] || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                                     e.name, ctrl_v, cyc, e.val[9:0], e.cyc);
                        end
                    end
                    prev_ctrl = ctrl_v;
                end
                if (coin_pending !== prev_pend) begin
                    n_vec++;
                    if (pend_q.size() == 0) begin
                        n_err++;
                        $display("FAIL pend_unexpected: got %0d at cycle %0d, required no change from %0d",
                                 coin_pending, cyc, prev_pend);
                    end else begin
                        e = pend_q.pop_front();
                        if (coin_pending !== e.val[1:0] || cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                                     e.name, coin_pending, cyc, e.val[1:0], e.cyc);
                        end
                    end
                    prev_pend = coin_pending;
                end
                if (coin1 === 1'b1 && prev_coin === 1'b0) begin
                    n_vec++;
                    if (rise_q.size() == 0) begin
                        n_err++;
                        $display("FAIL coin_unexpected: got coin1 rise at cycle %0d, required none", cyc);
                    end else begin
                        e = rise_q.pop_front();
                        if (cyc != e.cyc) begin
                            n_err++;
                            $display("FAIL %s: got rise at cycle %0d, required cycle %0d",
                                     e.name, cyc, e.cyc);
                        end
                    end
                    rise_cyc = cyc;
                end
                if (coin1 === 1'b0 && prev_coin === 1'b1) begin
                    n_vec++;
                    if (cyc - rise_cyc != TB_PULSE) begin
                        n_err++;
                        $display("FAIL coin_width: got %0d cycles high, required %0d",
                                 cyc - rise_cyc, TB_PULSE);
                    end
                end
                prev_coin = coin1;
            end
            if (done) begin
                n_vec++;
                if (ctrl_q.size() + pend_q.size() + rise_q.size() + snap_q.size() != 0) begin
                    n_err++;
                    $display("FAIL final_drain: %0d expected events never seen, required 0",
                             ctrl_q.size() + pend_q.size() + rise_q.size() + snap_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

endmodule
